// File: rtl/tof_pkg.sv
// ---------------------------------------------------------------------------
// tof_pkg
// Shared definitions for the VL53L0X time-of-flight sampling logic: the
// sequencer state encoding, sensor register constants and default timing
// derived from the 27 MHz system clock.
// ---------------------------------------------------------------------------
package tof_pkg;

    localparam int CLK_HZ    = 27_000_000;
    localparam int SAMPLE_HZ = 30;

    // VL53L0X bus address and the first result register of a ranging readout
    localparam logic [6:0] VL53_DEV_ADDR       = 7'h29;
    localparam logic [7:0] RESULT_RANGE_STATUS = 8'h14;

    // Byte offsets inside the result block starting at RESULT_RANGE_STATUS
    localparam int RANGE_STATUS_OFFSET = 0;
    localparam int RANGE_MSB_OFFSET    = 10;

    // 30 Hz sample period and a 10 ms limit on each register read
    localparam int DEFAULT_PERIOD_CYCLES = CLK_HZ / SAMPLE_HZ;
    localparam int DEFAULT_DONE_TIMEOUT  = CLK_HZ / 100;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        START       = 3'd1,
        WAIT_DONE   = 3'd2,
        POP         = 3'd3,
        CAPTURE     = 3'd4,
        PUBLISH     = 3'd5,
        FAIL        = 3'd6,
        WAIT_PERIOD = 3'd7
    } tof_state_t;

endpackage

// File: rtl/tof_period_timer.sv
// ---------------------------------------------------------------------------
// tof_period_timer
// Loadable down-counter. After a load it counts down once to zero and
// raises tc for exactly one cycle when it gets there, then stays idle until
// the next load.
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous, active-low reset
//   load       - load load_value and arm the counter
//   load_value - number of cycles after the load cycle before tc (tc fires
//                load_value+1 cycles after load is sampled)
//   tc         - one-cycle terminal-count pulse
// ---------------------------------------------------------------------------
module tof_period_timer #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count;
    logic             active;

    // A fresh load always wins, so a restart in the same cycle as the
    // terminal count simply re-arms the counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            active <= 1'b0;
        end else if (load) begin
            count  <= load_value;
            active <= 1'b1;
        end else if (active) begin
            if (count == '0) begin
                active <= 1'b0;
            end else begin
                count <= count - WIDTH'(1);
            end
        end
    end

    assign tc = active && (count == '0);

endmodule

// File: rtl/tof_range_sampler.sv
// ---------------------------------------------------------------------------
// tof_range_sampler
// Periodically starts the VL53L0X register-read engine, waits for it to
// finish, drains its read FIFO one byte at a time and publishes the range
// (mm) and range-status byte as a one-cycle valid pulse. Failed, timed-out
// or short reads are counted; three in a row raise a sticky sensor_error.
//
// Ports:
//   clk, reset            - system clock, asynchronous active-low reset
//   enable                - sample while high
//   rd_start              - one-cycle start pulse to the read engine
//   rd_dev_address        - I2C address for the engine (DEV_ADDR)
//   rd_reg_address        - first register to read (RESULT_REG)
//   rd_byte_width         - bytes per read (READ_BYTES)
//   rd_done, rd_failure   - engine completion / message failure
//   fifo_data             - FIFO read data
//   fifo_read_en          - one-cycle FIFO pop
//   fifo_empty            - FIFO empty flag
//   fifo_read_valid       - fifo_data valid, one cycle after the pop
//   range_mm              - last good range in millimetres
//   range_status          - last good range-status byte
//   range_valid           - one-cycle pulse when the two above update
//   fail_count            - saturating count of consecutive failures
//   sensor_error          - sticky, set once failures reach MAX_FAILS
//   state_out             - debug copy of the state register
// ---------------------------------------------------------------------------
module tof_range_sampler
    import tof_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR      = VL53_DEV_ADDR,
    parameter logic [7:0] RESULT_REG    = RESULT_RANGE_STATUS,
    parameter int         READ_BYTES    = 12,
    parameter int         STATUS_IDX    = RANGE_STATUS_OFFSET,
    parameter int         RANGE_MSB_IDX = RANGE_MSB_OFFSET,
    parameter int         PERIOD_CYCLES = DEFAULT_PERIOD_CYCLES,
    parameter int         DONE_TIMEOUT  = DEFAULT_DONE_TIMEOUT,
    parameter int         MAX_FAILS     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        rd_start,
    output logic [6:0]  rd_dev_address,
    output logic [7:0]  rd_reg_address,
    output logic [3:0]  rd_byte_width,
    input  logic        rd_done,
    input  logic        rd_failure,
    input  logic [7:0]  fifo_data,
    output logic        fifo_read_en,
    input  logic        fifo_empty,
    input  logic        fifo_read_valid,
    output logic [15:0] range_mm,
    output logic [7:0]  range_status,
    output logic        range_valid,
    output logic [1:0]  fail_count,
    output logic        sensor_error,
    output logic [2:0]  state_out
);

    localparam int TIMER_MAX = (PERIOD_CYCLES > DONE_TIMEOUT) ? PERIOD_CYCLES : DONE_TIMEOUT;
    localparam int CNT_W     = $clog2(TIMER_MAX + 1);

    // The period timer is loaded in START and its tc lets WAIT_PERIOD leave
    // on the following edge, so loading PERIOD_CYCLES-2 spaces STARTs
    // exactly PERIOD_CYCLES apart. The done timer leaves WAIT_DONE after
    // DONE_TIMEOUT cycles there.
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(PERIOD_CYCLES - 2);
    localparam logic [CNT_W-1:0] DONE_LOAD   = CNT_W'(DONE_TIMEOUT - 1);

    localparam logic [3:0] LAST_IDX   = 4'(READ_BYTES - 1);
    localparam logic [3:0] STATUS_POS = 4'(STATUS_IDX);
    localparam logic [3:0] MSB_POS    = 4'(RANGE_MSB_IDX);
    localparam logic [3:0] LSB_POS    = 4'(RANGE_MSB_IDX + 1);

    // Reject configurations whose byte indices fall outside the read block
    if (READ_BYTES < 1 || READ_BYTES > 15) begin : g_bad_read_bytes
        $error("tof_range_sampler: READ_BYTES must lie in 1..15");
    end
    if (STATUS_IDX < 0 || STATUS_IDX >= READ_BYTES) begin : g_bad_status_idx
        $error("tof_range_sampler: STATUS_IDX outside the read block");
    end
    if (RANGE_MSB_IDX < 0 || RANGE_MSB_IDX + 1 >= READ_BYTES) begin : g_bad_range_idx
        $error("tof_range_sampler: range bytes outside the read block");
    end
    if (PERIOD_CYCLES < 2 || DONE_TIMEOUT < 1 || MAX_FAILS < 1) begin : g_bad_timing
        $error("tof_range_sampler: PERIOD_CYCLES >= 2, DONE_TIMEOUT >= 1, MAX_FAILS >= 1 required");
    end

    tof_state_t state;
    logic [3:0] byte_idx;
    logic [1:0] cap_wait;
    logic [7:0] status_sh;
    logic [7:0] msb_sh;
    logic [7:0] lsb_sh;
    logic       period_pending;
    logic       period_tc;
    logic       done_tc;
    logic       timers_load;

    assign rd_dev_address = DEV_ADDR;
    assign rd_reg_address = RESULT_REG;
    assign rd_byte_width  = 4'(READ_BYTES);
    assign state_out      = state;
    assign timers_load    = (state == START);

    tof_period_timer #(.WIDTH(CNT_W)) u_period_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timers_load),
        .load_value (PERIOD_LOAD),
        .tc         (period_tc)
    );

    tof_period_timer #(.WIDTH(CNT_W)) u_done_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timers_load),
        .load_value (DONE_LOAD),
        .tc         (done_tc)
    );

    // Sequencer. All handshake and result outputs are registered here; the
    // pulses default low every cycle. period_pending remembers a period
    // expiry that happened while a long transaction was still running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            rd_start       <= 1'b0;
            fifo_read_en   <= 1'b0;
            range_mm       <= '0;
            range_status   <= '0;
            range_valid    <= 1'b0;
            fail_count     <= '0;
            sensor_error   <= 1'b0;
            byte_idx       <= '0;
            cap_wait       <= '0;
            status_sh      <= '0;
            msb_sh         <= '0;
            lsb_sh         <= '0;
            period_pending <= 1'b0;
        end else begin
            rd_start     <= 1'b0;
            fifo_read_en <= 1'b0;
            range_valid  <= 1'b0;

            if (state == START) begin
                period_pending <= 1'b0;
            end else if (period_tc) begin
                period_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= START;
                    end
                end
                START: begin
                    rd_start <= 1'b1;
                    state    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A failure reported together with done still counts as a failure
                    if (rd_failure || done_tc) begin
                        state <= FAIL;
                    end else if (rd_done) begin
                        byte_idx <= '0;
                        state    <= POP;
                    end
                end
                POP: begin
                    if (fifo_empty) begin
                        state <= FAIL;
                    end else begin
                        fifo_read_en <= 1'b1;
                        cap_wait     <= '0;
                        state        <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (fifo_read_valid) begin
                        if (byte_idx == STATUS_POS) begin
                            status_sh <= fifo_data;
                        end
                        if (byte_idx == MSB_POS) begin
                            msb_sh <= fifo_data;
                        end
                        if (byte_idx == LSB_POS) begin
                            lsb_sh <= fifo_data;
                        end
                        byte_idx <= byte_idx + 4'd1;
                        state    <= (byte_idx == LAST_IDX) ? PUBLISH : POP;
                    end else if (cap_wait == 2'd3) begin
                        state <= FAIL;
                    end else begin
                        cap_wait <= cap_wait + 2'd1;
                    end
                end
                PUBLISH: begin
                    range_mm     <= {msb_sh, lsb_sh};
                    range_status <= status_sh;
                    range_valid  <= 1'b1;
                    fail_count   <= '0;
                    state        <= enable ? WAIT_PERIOD : IDLE;
                end
                FAIL: begin
                    fail_count <= (fail_count == 2'd3) ? 2'd3 : fail_count + 2'd1;
                    if (int'(fail_count) + 1 >= MAX_FAILS) begin
                        sensor_error <= 1'b1;
                    end
                    state <= enable ? WAIT_PERIOD : IDLE;
                end
                WAIT_PERIOD: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (period_pending || period_tc) begin
                        state <= START;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tof_range_sampler.sv
// ---------------------------------------------------------------------------
// tb_tof_range_sampler
// Directed bench for tof_range_sampler with a shortened sample period and
// done timeout. A behavioural FIFO answers each pop with data one cycle
// later; the read engine's done/failure strobes are driven by the main
// sequence.
// ---------------------------------------------------------------------------
module tb_tof_range_sampler;

    localparam int PERIOD  = 200;
    localparam int TIMEOUT = 60;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_DONE = 3'd2;
    localparam logic [2:0] ST_CAPTURE   = 3'd4;
    localparam logic [2:0] ST_FAIL      = 3'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        rd_start;
    logic [6:0]  rd_dev_address;
    logic [7:0]  rd_reg_address;
    logic [3:0]  rd_byte_width;
    logic        rd_done;
    logic        rd_failure;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_read_en;
    logic        fifo_empty;
    logic        fifo_read_valid = 1'b0;
    logic [15:0] range_mm;
    logic [7:0]  range_status;
    logic        range_valid;
    logic [1:0]  fail_count;
    logic        sensor_error;
    logic [2:0]  state_out;

    int compared   = 0;
    int mismatched = 0;

    tof_range_sampler #(
        .PERIOD_CYCLES (PERIOD),
        .DONE_TIMEOUT  (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .rd_start        (rd_start),
        .rd_dev_address  (rd_dev_address),
        .rd_reg_address  (rd_reg_address),
        .rd_byte_width   (rd_byte_width),
        .rd_done         (rd_done),
        .rd_failure      (rd_failure),
        .fifo_data       (fifo_data),
        .fifo_read_en    (fifo_read_en),
        .fifo_empty      (fifo_empty),
        .fifo_read_valid (fifo_read_valid),
        .range_mm        (range_mm),
        .range_status    (range_status),
        .range_valid     (range_valid),
        .fail_count      (fail_count),
        .sensor_error    (sensor_error),
        .state_out       (state_out)
    );

    always #5 clk = ~clk;

    // Cycle counter: value k during the cycle that follows the k-th rising edge
    int cycle = 0;
    always begin
        @(posedge clk);
        cycle = cycle + 1;
    end

    // Behavioural read FIFO: a pop seen during a cycle returns its byte
    // with fifo_read_valid during the next cycle.
    logic [7:0] fifo_mem [0:63];
    int  wr_ptr    = 0;
    int  rd_ptr    = 0;
    int  pop_count = 0;
    logic pop_req  = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always begin
        @(negedge clk);
        pop_req = fifo_read_en;
        @(posedge clk);
        #1;
        if (pop_req) begin
            pop_count = pop_count + 1;
        end
        if (pop_req && (wr_ptr != rd_ptr)) begin
            fifo_data       = fifo_mem[6'(rd_ptr)];
            rd_ptr          = rd_ptr + 1;
            fifo_read_valid = 1'b1;
        end else begin
            fifo_read_valid = 1'b0;
        end
    end

    // Pulse monitor: records when rd_start and range_valid are seen and
    // flags any pulse that lasts more than one cycle.
    int   start_cnt        = 0;
    int   last_start_cycle = 0;
    int   prev_start_cycle = 0;
    int   valid_cnt        = 0;
    int   last_valid_cycle = 0;
    logic start_prev       = 1'b0;
    logic valid_prev       = 1'b0;
    logic dbl_start        = 1'b0;
    logic dbl_valid        = 1'b0;

    always begin
        @(negedge clk);
        if (rd_start) begin
            if (start_prev) dbl_start = 1'b1;
            prev_start_cycle = last_start_cycle;
            last_start_cycle = cycle;
            start_cnt        = start_cnt + 1;
        end
        if (range_valid) begin
            if (valid_prev) dbl_valid = 1'b1;
            last_valid_cycle = cycle;
            valid_cnt        = valid_cnt + 1;
        end
        start_prev = rd_start;
        valid_prev = range_valid;
    end

    // Hard stop in case the sequence itself stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed run still active, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        compared = compared + 1;
        assert (observed === expected) else begin
            mismatched = mismatched + 1;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_start(input string tag, input int budget);
        int base = start_cnt;
        int n    = 0;
        while (start_cnt == base && n < budget) begin
            tick();
            n = n + 1;
        end
        check_output(tag, 64'(start_cnt != base), 64'd1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int base = valid_cnt;
        int n    = 0;
        while (valid_cnt == base && n < budget) begin
            tick();
            n = n + 1;
        end
        check_output(tag, 64'(valid_cnt != base), 64'd1);
    endtask

    // Loads n bytes whose value is their index, except the status, MSB and
    // LSB positions which get the supplied values.
    task automatic load_fifo(input int n, input logic [7:0] status,
                             input logic [7:0] msb, input logic [7:0] lsb);
        logic [7:0] b;
        wr_ptr = rd_ptr;
        for (int i = 0; i < n; i++) begin
            b = 8'(i);
            if (i == 0)  b = status;
            if (i == 10) b = msb;
            if (i == 11) b = lsb;
            fifo_mem[6'(wr_ptr + i)] = b;
        end
        wr_ptr = wr_ptr + n;
    endtask

    task automatic pulse_engine(input logic done, input logic failure);
        rd_done    = done;
        rd_failure = failure;
        tick();
        rd_done    = 1'b0;
        rd_failure = 1'b0;
    endtask

    int done_cycle;
    int base_pops;
    int base_valid;
    int rel_cycle;

    initial begin
        reset      = 1'b0;
        enable     = 1'b0;
        rd_done    = 1'b0;
        rd_failure = 1'b0;
        $display("[TB] tof_range_sampler directed test starting");

        // Reset state and tie-offs
        ticks(3);
        check_output("reset_outputs", 64'({rd_start, fifo_read_en, range_valid, sensor_error,
                     fail_count, state_out, range_status, range_mm}), 64'd0);
        check_output("dev_address", 64'(rd_dev_address), 64'h29);
        check_output("reg_address", 64'(rd_reg_address), 64'h14);
        check_output("byte_width", 64'(rd_byte_width), 64'd12);

        // Read 1: bytes 0x00..0x0B
        reset  = 1'b1;
        enable = 1'b1;
        wait_start("start_1", 10);
        base_pops = pop_count;
        load_fifo(12, 8'h00, 8'h0A, 8'h0B);
        done_cycle = cycle;
        pulse_engine(1'b1, 1'b0);
        wait_valid("valid_1", 60);
        check_output("range_1", 64'(range_mm), 64'h0A0B);
        check_output("status_1", 64'(range_status), 64'h00);
        check_output("latency_1", 64'(last_valid_cycle - done_cycle), 64'd38);
        check_output("pops_1", 64'(pop_count - base_pops), 64'd12);
        check_output("fail_count_1", 64'(fail_count), 64'd0);

        // Read 2: different data, start spacing
        wait_start("start_2", PERIOD + 10);
        check_output("period_2", 64'(last_start_cycle - prev_start_cycle), 64'(PERIOD));
        load_fifo(12, 8'h07, 8'h12, 8'h34);
        pulse_engine(1'b1, 1'b0);
        wait_valid("valid_2", 60);
        check_output("range_2", 64'(range_mm), 64'h1234);
        check_output("status_2", 64'(range_status), 64'h07);

        // Reads 3-5: failures; the first reports done and failure together
        for (int k = 1; k <= 3; k++) begin
            wait_start($sformatf("start_fail_%0d", k), PERIOD + 10);
            check_output($sformatf("period_fail_%0d", k),
                         64'(last_start_cycle - prev_start_cycle), 64'(PERIOD));
            base_pops  = pop_count;
            base_valid = valid_cnt;
            if (k == 1) begin
                load_fifo(12, 8'hEE, 8'hEE, 8'hEE);
                pulse_engine(1'b1, 1'b1);
            end else begin
                pulse_engine(1'b0, 1'b1);
            end
            ticks(3);
            check_output($sformatf("fail_count_%0d", k), 64'(fail_count), 64'(k));
            check_output($sformatf("sensor_error_%0d", k), 64'(sensor_error), 64'(k >= 3));
            check_output($sformatf("range_hold_%0d", k), 64'(range_mm), 64'h1234);
            check_output($sformatf("pops_fail_%0d", k), 64'(pop_count - base_pops), 64'd0);
            check_output($sformatf("valid_fail_%0d", k), 64'(valid_cnt - base_valid), 64'd0);
        end

        // Read 6: engine silent, done timeout
        wait_start("start_timeout", PERIOD + 10);
        ticks(TIMEOUT - 1);
        check_output("timeout_before", 64'(state_out), 64'(ST_WAIT_DONE));
        tick();
        check_output("timeout_at", 64'(state_out), 64'(ST_FAIL));
        ticks(2);
        check_output("fail_count_saturate", 64'(fail_count), 64'd3);
        wait_start("start_after_timeout", PERIOD + 10);
        check_output("period_after_timeout", 64'(last_start_cycle - prev_start_cycle), 64'(PERIOD));

        // Read 7: good read clears fail_count, sensor_error stays
        load_fifo(12, 8'h05, 8'h04, 8'h56);
        done_cycle = cycle;
        pulse_engine(1'b1, 1'b0);
        wait_valid("valid_7", 60);
        check_output("range_7", 64'(range_mm), 64'h0456);
        check_output("status_7", 64'(range_status), 64'h05);
        check_output("latency_7", 64'(last_valid_cycle - done_cycle), 64'd38);
        check_output("fail_count_clear", 64'(fail_count), 64'd0);
        check_output("sensor_error_sticky", 64'(sensor_error), 64'd1);

        // Read 8: only five bytes in the FIFO
        wait_start("start_short", PERIOD + 10);
        base_pops  = pop_count;
        base_valid = valid_cnt;
        load_fifo(5, 8'h09, 8'h77, 8'h88);
        pulse_engine(1'b1, 1'b0);
        ticks(30);
        check_output("short_valid", 64'(valid_cnt - base_valid), 64'd0);
        check_output("short_pops", 64'(pop_count - base_pops), 64'd5);
        check_output("short_fail_count", 64'(fail_count), 64'd1);
        check_output("short_range_hold", 64'({range_status, range_mm}), 64'h05_0456);

        // Read 9: reset during capture of byte 4
        wait_start("start_reset", PERIOD + 10);
        base_pops = pop_count;
        load_fifo(12, 8'h01, 8'h02, 8'h03);
        pulse_engine(1'b1, 1'b0);
        ticks(13);
        check_output("capture_byte4", 64'(state_out), 64'(ST_CAPTURE));
        reset = 1'b0;
        #1;
        check_output("reset_mid_drain", 64'({rd_start, fifo_read_en, range_valid, sensor_error,
                     fail_count, state_out, range_status, range_mm}), 64'd0);
        ticks(5);
        check_output("pops_until_reset", 64'(pop_count - base_pops), 64'd5);
        wr_ptr = rd_ptr;
        reset = 1'b1;
        rel_cycle = cycle;
        wait_start("start_after_reset", 5);
        check_output("restart_latency", 64'(last_start_cycle - rel_cycle), 64'd2);

        // Enable drops mid-read: the read times out, then the block idles
        enable = 1'b0;
        ticks(TIMEOUT + 5);
        check_output("idle_after_disable", 64'(state_out), 64'(ST_IDLE));
        check_output("fail_count_disable", 64'(fail_count), 64'd1);

        check_output("single_cycle_start", 64'(dbl_start), 64'd0);
        check_output("single_cycle_valid", 64'(dbl_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
